// File: rtl/mlp_io_pkg.sv
// Shared types and defaults for the printed-MLP feature loader.
package mlp_io_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam int NUM_FEAT_DEF = 21;
    localparam int FEAT_W_DEF   = 4;
    localparam int CLS_W_DEF    = 2;

    // Width of the flat feature vector handed to the classifier.
    function automatic int vec_w(input int num_feat, input int feat_w);
        return num_feat * feat_w;
    endfunction

endpackage

// File: rtl/mlp_feature_loader.sv
// Streams quantized features into the classifier input vector, waits for the
// combinational network to settle, then returns the captured class index.
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accepting feature beats into mlp_inp, s_ready high
// SETTLE  | mlp_inp frozen, settle counter running toward terminal count
// RESULT  | class/err held on the result port until m_ready handshake
module mlp_feature_loader
    import mlp_io_pkg::*;
#(
    parameter int NUM_FEAT   = NUM_FEAT_DEF,
    parameter int FEAT_W     = FEAT_W_DEF,
    parameter int CLS_W      = CLS_W_DEF,
    parameter int SETTLE_CYC = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [FEAT_W-1:0]                     s_data,
    input  logic                                  s_last,
    output logic [vec_w(NUM_FEAT, FEAT_W)-1:0]    mlp_inp,
    input  logic [CLS_W-1:0]                      mlp_out,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [CLS_W-1:0]                      m_class,
    output logic                                  m_err,
    output logic                                  err_abort
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   settle_cnt;
    logic               err_flag;
    logic               accept;
    logic               last_slot;
    logic               settle_done;

    // Acceptance is decoded from state directly so s_ready never feeds back on itself.
    assign accept    = s_valid && (state == COLLECT);
    assign last_slot = (idx == IDX_LAST);

    // The counter runs one step past zero; the sign bit is the terminal count,
    // which places the capture on the (SETTLE_CYC+1)-th edge after the last beat.
    assign settle_done = settle_cnt[CNT_W-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the unregistered s_ready.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid && last_slot) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    // Feature packing, framing checks, settle timer and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            mlp_inp    <= '0;
            settle_cnt <= '0;
            err_flag   <= 1'b0;
            err_abort  <= 1'b0;
            m_valid    <= 1'b0;
            m_class    <= '0;
            m_err      <= 1'b0;
        end else begin
            err_abort <= 1'b0;

            if (accept) begin
                mlp_inp[idx*FEAT_W +: FEAT_W] <= s_data;
                if (last_slot) begin
                    idx        <= '0;
                    err_flag   <= !s_last;
                    settle_cnt <= CNT_LOAD;
                end else if (s_last) begin
                    idx       <= '0;
                    err_abort <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (state == SETTLE) begin
                if (settle_done) begin
                    m_class <= mlp_out;
                    m_err   <= err_flag;
                    m_valid <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
            end

            if ((state == RESULT) && m_ready) begin
                m_valid  <= 1'b0;
                err_flag <= 1'b0;
            end
        end
    end

endmodule
